uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (tx_data / new_tx_data / tx_busy) among NUM_REQ byte-stream requesters, for example the camera pixel serializer and the status/command-echo logic.
- Arbitration is round-robin with packet locking. A granted requester keeps the transmitter until it marks a byte as last, or until it stalls longer than HOLD_TIMEOUT cycles.
- Sits between the requesters and the UART TX core. All requester handshakes are valid/ready.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define ARB_FIXED_PRIORITY_EN to replace the round-robin pick with lowest-index-wins.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 arb_busy,
  output logic [1:0]           state_o
);

  // Handshake: a requester byte transfers only in a cycle where req_valid[i] and
  // req_ready[i] are both high; valid must not depend on ready.
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 new_tx_q, new_tx_d;
  logic                 last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 release_d;
  logic [IW-1:0]        win_idx;
  logic                 win_found;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_idx   = IW'(i);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid requester after last_grant wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IW'((int'(last_grant_q) + off) % NUM_REQ);
      if (req_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IW'(NUM_REQ - 1);
    end else if (release_d) begin
      last_grant_q <= gidx_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      tx_data_q <= 8'h00;
      new_tx_q  <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      tx_data_q <= tx_data_d;
      new_tx_q  <= new_tx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    release_d = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = NUM_REQ'(1) << win_idx;
          gidx_d  = win_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        req_ready = grant_q;
        if (req_valid[gidx_q]) begin
          tx_data_d = req_data[{gidx_q, 3'b000} +: 8];
          last_d    = req_last[gidx_q];
          cnt_d     = '0;
          state_d   = SEND;
        end else if (cnt_q == CNT_LAST) begin
          // Owner stalled too long: revoke so other requesters are not starved.
          grant_d   = '0;
          cnt_d     = '0;
          release_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (!tx_busy) begin
          new_tx_d = 1'b1;
          state_d  = GUARD;
        end
      end
      GUARD: begin
        // tx_busy is not consulted here: the UART raises it one cycle after the strobe.
        if (last_q) begin
          grant_d   = '0;
          release_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign arb_busy    = (state_q != IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: byte-queue requesters, strobe scoreboard, directed scenarios.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int HOLD_TIMEOUT = 255;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;
  logic                 arb_busy;
  logic [1:0]           state_o;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [NUM_REQ-1:0] fired = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    fired <= req_valid & req_ready;
  end

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];   // {requester index, byte}
  logic [8:0]  src0[$];    // {last, byte}
  logic [8:0]  src1[$];
  int          sc_q[$];    // cycle numbers of observed strobes
  logic [11:0] e;
  logic        prev_strobe = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && new_tx_data) begin
      check_eq("strobe_not_back_to_back", 32'(prev_strobe), 32'd0);
      check_eq("strobe_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("strobe_data", 32'(tx_data), 32'(e[7:0]));
        check_eq("strobe_grant", 32'(grant), 32'(1) << e[11:8]);
      end
      sc_q.push_back(cyc);
    end
    prev_strobe = !rst && new_tx_data;
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    req_valid[0]    = (src0.size() > 0);
    req_data[7:0]   = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
    req_last[0]     = (src0.size() > 0) ? src0[0][8] : 1'b0;
    req_valid[1]    = (src1.size() > 0);
    req_data[15:8]  = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
    req_last[1]     = (src1.size() > 0) ? src1[0][8] : 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    if (fired[0] && src0.size() > 0) void'(src0.pop_front());
    if (fired[1] && src1.size() > 0) void'(src1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_busy = 1'b0;
    exp_q.delete();
    src0.delete();
    src1.delete();
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_strobe(input int budget, input string tag);
    int n = 0;
    while (!new_tx_data && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(new_tx_data), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic r0_seen;
  logic early;
  logic unstable;

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;

    do_reset();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_new_tx", 32'(new_tx_data), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_arb_busy", 32'(arb_busy), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);

    // Single requester, three-byte packet, strobes 3 cycles apart.
    sc_q.delete();
    exp_q.push_back({4'd0, 8'h41});
    exp_q.push_back({4'd0, 8'h42});
    exp_q.push_back({4'd0, 8'h43});
    src0.push_back({1'b0, 8'h41});
    src0.push_back({1'b0, 8'h42});
    src0.push_back({1'b1, 8'h43});
    wait_done(40, "t1_done");
    step();
    check_eq("t1_grant_released", 32'(grant), 32'd0);
    check_eq("t1_arb_idle", 32'(arb_busy), 32'd0);
    check_eq("t1_strobe_count", 32'(sc_q.size()), 32'd3);
    if (sc_q.size() == 3) begin
      check_eq("t1_gap_1", 32'(sc_q[1] - sc_q[0]), 32'd3);
      check_eq("t1_gap_2", 32'(sc_q[2] - sc_q[1]), 32'd3);
    end

    // Simultaneous start with continuous 1-byte packets from both requesters.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back({1'b1, 8'(8'h10 + i)});
      src1.push_back({1'b1, 8'(8'h20 + i)});
    end
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd0, 8'(8'h10 + i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd1, 8'(8'h20 + i)});
`else
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'd0, 8'(8'h10 + i)});
      exp_q.push_back({4'd1, 8'(8'h20 + i)});
    end
`endif
    wait_done(100, "t2_done");

    // Packet lock: req1 four-byte packet, req0 arrives mid-packet.
    r0_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'd1, 8'(8'h30 + i)});
      src1.push_back({(i == 3), 8'(8'h30 + i)});
    end
    exp_q.push_back({4'd0, 8'h40});
    for (int i = 0; i < 4; i++) begin
      step();
      if (req_ready[0]) r0_seen = 1'b1;
    end
    src0.push_back({1'b1, 8'h40});
    for (int n = 0; n < 40 && exp_q.size() > 1; n++) begin
      step();
      if (req_ready[0]) r0_seen = 1'b1;
    end
    check_eq("t3_req1_bytes_first", 32'(exp_q.size()), 32'd1);
    check_eq("t3_ready0_held_low", 32'(r0_seen), 32'd0);
    wait_done(20, "t3_done");

    // Busy hold-off: tx_busy high for 20 cycles after first strobe.
    exp_q.push_back({4'd0, 8'h50});
    exp_q.push_back({4'd0, 8'h51});
    src0.push_back({1'b0, 8'h50});
    src0.push_back({1'b1, 8'h51});
    wait_strobe(20, "t4_first_strobe");
    tx_busy  = 1'b1;
    early    = 1'b0;
    unstable = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (new_tx_data) early = 1'b1;
      if (k >= 2 && tx_data !== 8'h51) unstable = 1'b1;
    end
    check_eq("t4_no_strobe_while_busy", 32'(early), 32'd0);
    check_eq("t4_tx_data_stable", 32'(unstable), 32'd0);
    tx_busy = 1'b0;
    step();
    check_eq("t4_strobe_after_busy", 32'(new_tx_data), 32'd1);
    check_eq("t4_strobe_data", 32'(tx_data), 32'h51);
    wait_done(10, "t4_done");

    // Timeout: req0 sends a non-last byte then stalls; req1 waits.
    do_reset();
    exp_q.push_back({4'd0, 8'h60});
    exp_q.push_back({4'd1, 8'h70});
    src0.push_back({1'b0, 8'h60});
    src1.push_back({1'b1, 8'h70});
    wait_strobe(20, "t5_first_strobe");
    repeat (HOLD_TIMEOUT) step();
    check_eq("t5_grant_held", 32'(grant), 32'd1);
    step();
    check_eq("t5_grant_revoked", 32'(grant), 32'd0);
    check_eq("t5_arb_idle", 32'(arb_busy), 32'd0);
    step();
    check_eq("t5_req1_granted", 32'(grant), 32'd2);
    wait_done(20, "t5_done");

    // Reset mid-packet while waiting in SEND.
    tx_busy = 1'b1;
    src0.push_back({1'b0, 8'h80});
    src0.push_back({1'b1, 8'h81});
    for (int n = 0; n < 10 && state_o != 2'd2; n++) step();
    check_eq("t6_reached_send", 32'(state_o), 32'd2);
    check_eq("t6_captured", 32'(tx_data), 32'h80);
    rst = 1'b1;
    step();
    check_eq("t6_rst_grant", 32'(grant), 32'd0);
    check_eq("t6_rst_new_tx", 32'(new_tx_data), 32'd0);
    check_eq("t6_rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("t6_rst_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    tx_busy = 1'b0;
    src0.delete();
    src1.delete();
    exp_q.push_back({4'd0, 8'h90});
    exp_q.push_back({4'd1, 8'h91});
    src0.push_back({1'b1, 8'h90});
    src1.push_back({1'b1, 8'h91});
    wait_done(40, "t6_done");

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
